// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg
// Shared types for the fetch->decode instruction queue.
// Contents:
//   PC_W, INST_W, ENTRY_W : widths taken from the shared param.v header
//   NOP_DEFAULT           : instruction shown to decode when the queue is empty
//   entry_t               : one queued {pc, inst} pair
//   q_op_e / classify_op  : the single pointer/count action taken on a clock edge
`include "param.v"

package if_id_queue_pkg;

  localparam int PC_W    = `WIDTH_PC;
  localparam int INST_W  = `WIDTH_INST;
  localparam int ENTRY_W = PC_W + INST_W;

  localparam logic [INST_W-1:0] NOP_DEFAULT = `INST_NOP;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  // Exactly one of these actions happens on each edge.
  typedef enum logic [2:0] {
    Q_IDLE,
    Q_PUSH,
    Q_POP,
    Q_PUSH_POP,
    Q_FLUSH
  } q_op_e;

  // flush wins over everything. push and pop must already be qualified by
  // ready and valid.
  function automatic q_op_e classify_op(input logic push, input logic pop,
                                        input logic flush);
    q_op_e op;
    if (flush) begin
      op = Q_FLUSH;
    end else if (push && pop) begin
      op = Q_PUSH_POP;
    end else if (push) begin
      op = Q_PUSH;
    end else if (pop) begin
      op = Q_POP;
    end else begin
      op = Q_IDLE;
    end
    return op;
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem
// Entry storage for the IF/ID queue. This is a DEPTH x W register array with
// one synchronous write port and one asynchronous (combinational) read port.
// The storage has no reset. Only the pointers in the parent module track
// which entries hold valid data.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, driven combinationally from raddr
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // The async read lets the head entry reach decode in the same cycle that
  // the read pointer points at it.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/param.v
// Shared processor-wide widths and constants.
// Every file that needs them pulls them in with an include. The guard keeps
// a second include from redefining the macros.
`ifndef PARAM_V_INCLUDED
`define PARAM_V_INCLUDED

`define WIDTH_PC   32
`define WIDTH_INST 32
// RISC-V canonical NOP: addi x0, x0, 0
`define INST_NOP   32'h00000013

`endif

// File: rtl/if_id_queue.sv
// if_id_queue
// Circular FIFO between fetch and decode. It carries pc/instruction pairs.
// A flush from a taken branch or jump drops every queued entry and any entry
// offered on that edge. When the queue is empty, decode sees a NOP at pc 0.
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : push handshake from fetch (in_ready = not full)
//   in_pc, in_inst       : offered entry
//   flush                : discard all entries; has priority over push and pop
//   out_valid / out_ready: pop handshake to decode (out_valid = not empty)
//   out_pc, out_inst     : head entry, or 0 / NOP_INST when empty
//   count                : current occupancy, 0..DEPTH
`include "param.v"

module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] NOP_INST = NOP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`WIDTH_PC-1:0]   in_pc,
  input  logic [`WIDTH_INST-1:0] in_inst,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`WIDTH_PC-1:0]   out_pc,
  output logic [`WIDTH_INST-1:0] out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic   push;
  logic   pop;
  q_op_e  op;
  entry_t wr_entry;
  entry_t rd_entry;

  // in_ready depends only on occupancy. A pop on the same edge never opens
  // room for a push in that cycle, so there is no out_ready -> in_ready path.
  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;
  assign op   = classify_op(push, pop, flush);

  // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
  // count only steps up on a push that in_ready allowed, and only steps down
  // on a pop that out_valid allowed. It therefore stays within 0..DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    unique case (op)
      Q_PUSH: begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
        count_next  = count_reg + CW'(1);
      end
      Q_POP: begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
        count_next  = count_reg - CW'(1);
      end
      Q_PUSH_POP: begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      Q_FLUSH: begin
        wr_ptr_next = '0;
        rd_ptr_next = '0;
        count_next  = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign wr_entry.pc   = in_pc;
  assign wr_entry.inst = in_inst;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (rd_entry)
  );

  // Stale storage must never leak out when the queue is empty. This includes
  // the cycles while rst is held, because count_reg is cleared asynchronously.
  assign out_pc   = out_valid ? rd_entry.pc   : '0;
  assign out_inst = out_valid ? rd_entry.inst : NOP_INST;
  assign count    = count_reg;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [INST_W-1:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_err = 0;
  bit done = 1'b0;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a plain queue ----------------
  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ent_t;
  ent_t q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      bit do_pop, do_push;
      ent_t e;
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = in_pc;
        e.inst = in_inst;
        q.push_back(e);
      end
    end
  end

  // One compare per cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      logic [PC_W-1:0]   epc;
      logic [INST_W-1:0] einst;
      epc   = (q.size() > 0) ? q[0].pc   : '0;
      einst = (q.size() > 0) ? q[0].inst : NOP;
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("m_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("m_out_pc", 64'(out_pc), 64'(epc));
      chk("m_out_inst", 64'(out_inst), 64'(einst));
      $display("cyc t=%0t rst=%0b iv=%0b ipc=%0h fl=%0b ordy=%0b | ov=%0b opc=%0h oinst=%0h cnt=%0d",
               $time, rst, in_valid, in_pc, flush, out_ready, out_valid, out_pc, out_inst, count);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
    return 32'h5A000000 ^ INST_W'(pc);
  endfunction

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic ordy,
                       input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic v; logic [31:0] pc; logic r; logic f; } vec_t;
  vec_t mix[12] = '{
    '{1'b1, 32'h200, 1'b0, 1'b0}, '{1'b1, 32'h204, 1'b1, 1'b0},
    '{1'b0, 32'h0,   1'b1, 1'b0}, '{1'b1, 32'h208, 1'b0, 1'b0},
    '{1'b1, 32'h20C, 1'b0, 1'b0}, '{1'b1, 32'h210, 1'b0, 1'b0},
    '{1'b1, 32'h214, 1'b0, 1'b0}, '{1'b1, 32'h218, 1'b0, 1'b0},
    '{1'b1, 32'h21C, 1'b1, 1'b0}, '{1'b0, 32'h0,   1'b0, 1'b1},
    '{1'b0, 32'h0,   1'b1, 1'b0}, '{1'b1, 32'h220, 1'b1, 1'b0}
  };

  initial begin
    // Reset state
    edge1();
    edge1();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'h13);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    rst = 1'b0;
    edge1();

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      edge1();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_pc", 64'(out_pc), 64'h0);
    // An offer while full must be refused
    drive(1'b1, 32'hEE, 1'b0, 1'b0);
    edge1();
    chk("full_hold_count", 64'(count), 64'd4);

    // Drain in order
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_pc), 64'(i * 4));
      edge1();
    end
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_out_inst", 64'(out_inst), 64'h13);
    // Pop while empty must not underflow
    edge1();
    chk("empty_count", 64'(count), 64'd0);

    // Count=2, then simultaneous push/pop for 8 cycles across wrap
    drive(1'b1, 32'h100, 1'b0, 1'b0); edge1();
    drive(1'b1, 32'h104, 1'b0, 1'b0); edge1();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'(32'h108 + 4 * k), 1'b1, 1'b0);
      chk("pp_head", 64'(out_pc), 64'(32'h100 + 4 * k));
      edge1();
      chk("pp_count", 64'(count), 64'd2);
    end
    chk("pp_head_end", 64'(out_pc), 64'h120);
    chk("pp_inst_end", 64'(out_inst), 64'(32'h5A000120));

    // Count=3 then flush with a concurrent push and pop
    drive(1'b1, 32'h128, 1'b0, 1'b0); edge1();
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h40, 1'b1, 1'b1); edge1();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("flush_no_0x40", 64'(out_valid), 64'd0);
    end

    // Push latency into empty queue: no bypass
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    chk("lat_before", 64'(out_valid), 64'd0);
    edge1();
    chk("lat_after_valid", 64'(out_valid), 64'd1);
    chk("lat_after_pc", 64'(out_pc), 64'h10);

    // Async reset between edges with count=3
    drive(1'b1, 32'h14, 1'b0, 1'b0); edge1();
    drive(1'b1, 32'h18, 1'b0, 1'b0); edge1();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_inst", 64'(out_inst), 64'h13);
    edge1();
    rst = 1'b0;
    drive(1'b1, 32'h80, 1'b0, 1'b0); edge1();
    drive(1'b1, 32'h84, 1'b0, 1'b0); edge1();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("arst_first_pc", 64'(out_pc), 64'h80);
    edge1();
    chk("arst_second_pc", 64'(out_pc), 64'h84);
    edge1();

    // Mixed directed table, checked by the model on every cycle
    for (int i = 0; i < 12; i++) begin
      drive(mix[i].v, mix[i].pc, mix[i].r, mix[i].f);
      edge1();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (6) edge1();
    chk("final_empty", 64'(count), 64'd0);

    @(posedge clk);
    done = 1'b1;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL be parameterised as: DEPTH, default 4, number of queue entries (power of two, at least 2).
REQ-002 The block SHALL be parameterised as: NOP_INST, default 32'h00000013, instruction presented when empty.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  fetch stage offers a pc/inst pair this cycle.
REQ-007 in_ready  output  1  queue accepts a push this cycle.
REQ-008 in_pc  input  `WIDTH_PC  pc of offered instruction.
REQ-009 in_inst  input  `WIDTH_INST  offered instruction word.
REQ-010 flush  input  1  taken branch/jump (fetch risk_Ctrl); discard all queued entries.
REQ-011 out_valid  output  1  head entry present for decode.
REQ-012 out_ready  input  1  decode consumes head this cycle (low = decode stall).
REQ-013 out_pc  output  `WIDTH_PC  pc of head entry.
REQ-014 out_inst  output  `WIDTH_INST  instruction of head entry.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push occurs on a rising edge when in_valid && in_ready && !flush; the entry is written at the write pointer.
REQ-017 Pop occurs on a rising edge when out_valid && out_ready && !flush; the read pointer advances.
REQ-018 in_ready SHALL equal (count != DEPTH), independent of out_ready (no same-cycle pop-enables-push path).
REQ-019 out_valid SHALL equal (count != 0); out_pc/out_inst SHALL be driven combinationally from the head entry.
REQ-020 When empty, out_inst SHALL be NOP_INST and out_pc SHALL be 0.
REQ-021 Latency: an entry pushed at edge N SHALL appear at the outputs after edge N when the queue was empty; there is no combinational in-to-out bypass.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, with both pointers advancing.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO across wrap-around.
REQ-024 flush SHALL take priority over push and pop: at that edge count SHALL become 0, both pointers SHALL become 0, and any offered in_valid entry SHALL be dropped.
REQ-025 Entry storage contents SHALL NOT be required to clear on flush or reset; only pointers and count SHALL clear.
REQ-026 count SHALL never exceed DEPTH nor underflow under any input combination.

Reset
REQ-027 While rst is high, pointers and count SHALL be 0, in_ready SHALL be 1, out_valid SHALL be 0, out_inst SHALL be NOP_INST, and out_pc SHALL be 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL be the first entry popped.

Structure
REQ-029 `WIDTH_PC, `WIDTH_INST and a shared `INST_NOP constant SHALL come from the shared param.v header; no widths SHALL be hard-coded.
REQ-030 One sub-module, if_id_queue_mem, SHALL hold the DEPTH x (`WIDTH_PC+`WIDTH_INST) register array with one synchronous write port and one asynchronous read port.
REQ-031 Pointer, count and flush logic SHALL reside in if_id_queue.

Verification
REQ-032 Reset, then push pc 0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0, out_pc=0x00.
REQ-033 From full, out_ready=1 for four cycles, no pushes -> out_pc 0x00,0x04,0x08,0x0C in order, then out_valid=0, out_inst=0x00000013.
REQ-034 Count=2, push and pop on the same edge for 8 cycles -> count stays 2 and pointers wrap with FIFO order preserved.
REQ-035 Count=3 with flush=1, in_valid=1 (pc 0x40), out_ready=1 on the same edge -> count=0 next cycle and 0x40 is not observed.
REQ-036 Push 0x10 at edge N into empty queue -> out_valid=0 before edge N, out_valid=1 and out_pc=0x10 after it.
REQ-037 Assert rst asynchronously between edges with count=3 -> out_valid falls immediately; next push 0x80 is popped first.
